// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: shared write bus, function select,
// read selects and the registered read/wrap outputs.
// There is no valid/ready handshake on this bus. Every field is sampled on
// every rising clock edge, and the outputs are valid one edge later.
interface param_register_file_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
);
  logic [WIDTH-1:0]    I;
  logic [NUM_REGS-1:0] RegEn;
  logic [2:0]          FunSel;
  logic [SEL_W-1:0]    OutASel;
  logic [SEL_W-1:0]    OutBSel;
  logic [WIDTH-1:0]    OutA;
  logic [WIDTH-1:0]    OutB;
  logic                Wrap;

  modport master (
    output I, RegEn, FunSel, OutASel, OutBSel,
    input  OutA, OutB, Wrap
  );

  modport slave (
    input  I, RegEn, FunSel, OutASel, OutBSel,
    output OutA, OutB, Wrap
  );
endinterface

// File: rtl/param_register_file.sv
// Parametrised register file: NUM_REGS x WIDTH registers. A shared function
// select is applied to every enabled register. There are two registered read
// ports with optional write-to-read bypass, and a registered wrap flag.
module param_register_file #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int BYPASS   = 0
) (
  input logic                  Clock,
  input logic                  Reset,
  param_register_file_if.slave bus
);
  localparam int H = WIDTH / 2;

  // Reject illegal parameter sets while the design is being elaborated.
  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("param_register_file: WIDTH must be even and >= 4");
    end
    if (NUM_REGS < 2 || NUM_REGS > 16) begin : g_bad_depth
      $error("param_register_file: NUM_REGS must be in 2..16");
    end
    if ((2 ** SEL_W) < NUM_REGS) begin : g_bad_sel
      $error("param_register_file: SEL_W too small for NUM_REGS");
    end
  endgenerate

  logic [WIDTH-1:0] regs     [NUM_REGS];
  logic [WIDTH-1:0] nxt      [NUM_REGS];
  logic [WIDTH-1:0] rd_src   [NUM_REGS];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             wrap_nxt;

  // Next value of each register, and the wrap condition for this edge.
  always_comb begin
    wrap_nxt = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      nxt[k] = regs[k];
      if (bus.RegEn[k]) begin
        case (bus.FunSel)
          3'b000: begin
            nxt[k] = regs[k] - WIDTH'(1);
            if (regs[k] == '0) wrap_nxt = 1'b1;
          end
          3'b001: begin
            nxt[k] = regs[k] + WIDTH'(1);
            if (regs[k] == '1) wrap_nxt = 1'b1;
          end
          3'b010: nxt[k] = bus.I;
          3'b011: nxt[k] = '0;
          3'b100: nxt[k] = {{H{1'b0}}, bus.I[H-1:0]};
          3'b101: nxt[k] = {regs[k][WIDTH-1:H], bus.I[H-1:0]};
          3'b110: nxt[k] = {regs[k][WIDTH-2:0], 1'b0};
          default: nxt[k] = {1'b0, regs[k][WIDTH-1:1]};
        endcase
      end
    end
  end

  // Read-port source and select mux. An index beyond the bank reads as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_src[k] = (BYPASS != 0) ? nxt[k] : regs[k];
      if (bus.OutASel == SEL_W'(k)) rd_a = rd_src[k];
      if (bus.OutBSel == SEL_W'(k)) rd_b = rd_src[k];
    end
  end

  // State and output registers. Reset discards the cycle's operation.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      bus.OutA <= '0;
      bus.OutB <= '0;
      bus.Wrap <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= nxt[k];
      bus.OutA <= rd_a;
      bus.OutB <= rd_b;
      bus.Wrap <= wrap_nxt;
    end
  end
endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the fixed 8x32 general/scratch register file.
- Bank of NUM_REGS registers, WIDTH bits each. A shared input bus and a shared function select drive every register whose enable bit is set.
- Two registered read ports, with optional write-to-read bypass and a registered wrap flag.
- Sits between the ALU/bus system and the control unit as the CPU's architectural-plus-scratch storage.

Parameters:
- WIDTH, 32, register and bus width in bits; must be even and at least 4.
- NUM_REGS, 8, number of registers; range 2 to 16, need not be a power of two.
- SEL_W, 3, read-select width; must satisfy 2**SEL_W >= NUM_REGS.
- BYPASS, 0, read-port source. 0: read ports sample pre-update contents. 1: read ports sample post-update contents in the same edge.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- I  input  WIDTH  data input bus
- RegEn  input  NUM_REGS  per-register enable; bit k selects register k; any number of bits may be set
- FunSel  input  3  operation applied to every enabled register
- OutASel  input  SEL_W  register index for read port A
- OutBSel  input  SEL_W  register index for read port B
- OutA  output  WIDTH  registered read port A
- OutB  output  WIDTH  registered read port B
- Wrap  output  1  registered; high for one cycle after any enabled register wrapped on increment or decrement

Behaviour:
- Reset has priority over all other inputs. On a rising edge with Reset=1:
  - all registers, OutA, OutB and Wrap clear to 0;
  - RegEn and FunSel are ignored;
  - Reset asserted mid-sequence discards that cycle's operation.
- Register k with RegEn[k]=0 holds its value.
- Register k with RegEn[k]=1 updates at the rising edge per FunSel (H = WIDTH/2):
  - 000 decrement: Q-1 modulo 2**WIDTH.
  - 001 increment: Q+1 modulo 2**WIDTH.
  - 010 load: Q=I.
  - 011 clear: Q=0.
  - 100 load low, zero-extend: Q = {H zeros, I[H-1:0]}.
  - 101 load low, keep high: Q = {Q[WIDTH-1:H], I[H-1:0]}.
  - 110 shift left logical by 1, LSB filled with 0.
  - 111 shift right logical by 1, MSB filled with 0.
- Wrap is registered each edge.
  - Set to 1 if any enabled register goes 0 -> all-ones on 000, or all-ones -> 0 on 001. Otherwise set to 0.
  - Wrap therefore lasts exactly one cycle per wrapping edge.
- Read ports are registered with 1-cycle latency. OutA/OutB update every non-reset edge from the register indexed by OutASel/OutBSel.
  - BYPASS=0: sampled value is the register content before this edge's update.
  - BYPASS=1: sampled value is the content this edge writes; for an unenabled register, its held content.
- A select index >= NUM_REGS reads as 0 and does not fault.
- OutASel and OutBSel may be equal; both ports return the same value.
- Simultaneous update and read of the same register in one cycle is legal. Result is as defined by BYPASS above; no stall, no hazard signal.
- Combinational read paths are forbidden; all outputs come straight from flops.
- Parameter violations (odd WIDTH, SEL_W too small) halt elaboration with an error.

Test Plan:
- Reset: drive arbitrary data for 5 cycles, then Reset=1 for one edge -> OutA=OutB=0 and Wrap=0 on the next cycle. Every register then reads 0 via the read ports.
- Load and readback, default params: RegEn=8'b0000_0100, FunSel=010, I=32'hDEAD_BEEF at edge n.
  - With OutASel=2 at edge n+1, OutA=32'hDEAD_BEEF after n+1.
  - OutASel=2 sampled at edge n (BYPASS=0) returns the old value 0.
- Wrap on increment: load 32'hFFFF_FFFF into register 0, then FunSel=001 with RegEn[0]=1 -> register 0 = 0 and Wrap=1 for exactly one cycle.
  - Repeat with FunSel=000 from 0 -> 32'hFFFF_FFFF, Wrap=1.
- Half loads and shifts: register 3 = 32'h1234_5678.
  - FunSel=101 with I=32'hAAAA_BBBB -> 32'h1234_BBBB.
  - Then FunSel=100 -> 32'h0000_BBBB.
  - Then FunSel=110 -> 32'h0001_7776.
  - Then FunSel=111 -> 32'h0000_BBBB.
- Multi-enable and bypass: BYPASS=1, RegEn=all ones, FunSel=010, I=32'h0000_0055, OutASel=5, OutBSel=7 in the same edge -> OutA=OutB=32'h0000_0055 immediately after that edge.
- Odd depth: NUM_REGS=6, WIDTH=16, SEL_W=3. OutASel=6 and OutBSel=7 -> OutA=OutB=16'h0000. Register 5 loaded with 16'h00F0 reads back 16'h00F0 on OutASel=5.
